// File: rtl/turret_projectile.sv
// Left-turret shell launcher and per-frame flight engine.
// Ports: Clk/Reset, frame_tick, keycode, motion_x/y in; bullet_x/y, bullet_active, ready, shots_fired out.
module turret_projectile #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] ORIGIN_X        = 10'd100,
  parameter logic [9:0] ORIGIN_Y        = 10'd400,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MAX           = 10'd479,
  parameter logic [1:0] SPEED           = 2'd1,
  parameter logic [3:0] GRAV_DIV        = 4'd4,
  parameter logic [9:0] VY_MAX          = 10'd8,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] motion_x,
  input  logic [9:0] motion_y,
  input  logic       target_hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       ready,
  output logic [7:0] shots_fired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLIGHT,
    S_COOL
  } state_t;

  state_t state, state_n;

  logic               key_q;
  logic               key_hit;
  logic               fire_edge;
  logic signed [10:0] vx, vy;
  logic        [3:0]  gcnt;
  logic        [5:0]  ccnt;
  logic signed [11:0] spd;
  logic signed [11:0] step_x, step_y;
  logic signed [11:0] nx, ny;
  logic               oob;
  logic               move;

  assign key_hit   = (keycode == FIRE_KEY);
  assign fire_edge = key_hit & ~key_q;

  assign spd    = $signed({10'd0, SPEED});
  assign step_x = $signed({vx[10], vx}) * spd;
  assign step_y = $signed({vy[10], vy}) * spd;
  assign nx     = $signed({2'b00, bullet_x}) + step_x;
  assign ny     = $signed({2'b00, bullet_y}) + step_y;

  // Negative results show up in bit 11; wrap of very large steps also
  // lands negative, so it still terminates the flight.
  assign oob = nx[11] | ny[11]
             | (nx > $signed({2'b00, X_MAX}))
             | (ny > $signed({2'b00, Y_MAX}));

  // Hit outranks the tick, so a hit never moves the shell.
  assign move = (state == S_FLIGHT) & frame_tick & ~target_hit & ~oob;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (fire_edge) state_n = S_LAUNCH;
      S_LAUNCH: state_n = S_FLIGHT;
      S_FLIGHT: begin
        if (target_hit)            state_n = S_COOL;
        else if (frame_tick && oob) state_n = S_COOL;
      end
      S_COOL:   if (ccnt == 6'd0) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      key_q         <= 1'b0;
      bullet_x      <= ORIGIN_X;
      bullet_y      <= ORIGIN_Y;
      vx            <= '0;
      vy            <= '0;
      gcnt          <= '0;
      ccnt          <= '0;
      shots_fired   <= '0;
      bullet_active <= 1'b0;
      ready         <= 1'b1;
    end else begin
      state         <= state_n;
      key_q         <= key_hit;
      bullet_active <= (state_n == S_FLIGHT);
      ready         <= (state_n == S_IDLE);

      if (state == S_LAUNCH) begin
        bullet_x <= ORIGIN_X;
        bullet_y <= ORIGIN_Y;
        vx       <= {motion_x[9], motion_x};
        vy       <= {motion_y[9], motion_y};
        gcnt     <= '0;
        if (shots_fired != 8'hFF) shots_fired <= shots_fired + 8'd1;
      end

      if (move) begin
        bullet_x <= nx[9:0];
        bullet_y <= ny[9:0];
        if (GRAV_DIV != 4'd0) begin
          if (gcnt == GRAV_DIV - 4'd1) begin
            gcnt <= '0;
            if (vy < $signed({1'b0, VY_MAX})) vy <= vy + 11'sd1;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
      end

      if (state == S_FLIGHT && state_n == S_COOL)
        ccnt <= COOLDOWN_FRAMES;
      else if (state == S_COOL && frame_tick && ccnt != 6'd0)
        ccnt <= ccnt - 6'd1;
    end
  end

endmodule

// File: tb/tb_turret_projectile.sv
// Directed bench for turret_projectile: launch/step table plus
// hand sequences for cooldown, exits, reset, hold and gravity.
module tb_turret_projectile;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] motion_x = '0;
  logic [9:0] motion_y = '0;
  logic       target_hit = 1'b0;

  logic [9:0] bx0, by0, bx1, by1, bx2, by2;
  logic       ba0, rd0, ba1, rd1, ba2, rd2;
  logic [7:0] sf0, sf1, sf2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  turret_projectile u0 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .keycode(keycode), .motion_x(motion_x), .motion_y(motion_y),
    .target_hit(target_hit), .bullet_x(bx0), .bullet_y(by0),
    .bullet_active(ba0), .ready(rd0), .shots_fired(sf0)
  );

  turret_projectile #(
    .ORIGIN_X(10'd637), .GRAV_DIV(4'd0), .COOLDOWN_FRAMES(6'd2)
  ) u1 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .keycode(keycode), .motion_x(motion_x), .motion_y(motion_y),
    .target_hit(target_hit), .bullet_x(bx1), .bullet_y(by1),
    .bullet_active(ba1), .ready(rd1), .shots_fired(sf1)
  );

  turret_projectile #(
    .GRAV_DIV(4'd1), .VY_MAX(10'd8)
  ) u2 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .keycode(keycode), .motion_x(motion_x), .motion_y(motion_y),
    .target_hit(target_hit), .bullet_x(bx2), .bullet_y(by2),
    .bullet_active(ba2), .ready(rd2), .shots_fired(sf2)
  );

  typedef struct {
    logic       tick;
    logic [7:0] key;
    logic [9:0] mx;
    logic [9:0] my;
    logic       hit;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       ea;
    logic       er;
    logic [7:0] es;
  } vec_t;

  vec_t tbl[12];
  int   gy[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic h);
    frame_tick = t;
    target_hit = h;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    target_hit = 1'b0;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    keycode = 8'h00;
    cyc(0, 0);
    cyc(0, 0);
    Reset = 1'b0;
  endtask

  task automatic fire();
    keycode = 8'h2C;
    cyc(0, 0);
    keycode = 8'h00;
    cyc(0, 0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h2C, 10'd2, 10'h3FF, 1'b0, 10'd100, 10'd400, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 8'h2C, 10'd2, 10'h3FF, 1'b0, 10'd100, 10'd400, 1'b1, 1'b0, 8'd1};
    tbl[2]  = '{1'b0, 8'h2C, 10'd2, 10'h3FF, 1'b0, 10'd100, 10'd400, 1'b1, 1'b0, 8'd1};
    tbl[3]  = '{1'b0, 8'h00, 10'd2, 10'h3FF, 1'b0, 10'd100, 10'd400, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 8'h00, 10'd2, 10'h3FF, 1'b0, 10'd102, 10'd399, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{1'b0, 8'h2C, 10'd5, 10'd5,   1'b0, 10'd102, 10'd399, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 8'h00, 10'd5, 10'd5,   1'b0, 10'd104, 10'd398, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 8'h00, 10'd5, 10'd5,   1'b0, 10'd106, 10'd397, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 8'h00, 10'd5, 10'd5,   1'b0, 10'd108, 10'd396, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 8'h00, 10'd5, 10'd5,   1'b0, 10'd110, 10'd396, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 8'h00, 10'd5, 10'd5,   1'b1, 10'd110, 10'd396, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 8'h2C, 10'd5, 10'd5,   1'b0, 10'd110, 10'd396, 1'b0, 1'b0, 8'd1};
    gy = '{405, 411, 418, 426, 434, 442, 450, 458, 466, 474};

    // Reset state
    do_reset();
    chk("rst_x", bx0, 100);
    chk("rst_y", by0, 400);
    chk("rst_active", ba0, 0);
    chk("rst_ready", rd0, 1);
    chk("rst_shots", sf0, 0);

    // Launch, step, motion latch, dropped presses, hit priority
    for (int i = 0; i < 12; i++) begin
      keycode  = tbl[i].key;
      motion_x = tbl[i].mx;
      motion_y = tbl[i].my;
      cyc(tbl[i].tick, tbl[i].hit);
      chk($sformatf("tbl%0d_x", i), bx0, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), by0, tbl[i].ey);
      chk($sformatf("tbl%0d_active", i), ba0, tbl[i].ea);
      chk($sformatf("tbl%0d_ready", i), rd0, tbl[i].er);
      chk($sformatf("tbl%0d_shots", i), sf0, tbl[i].es);
    end

    // Default cooldown of 30 frames, then re-fire
    keycode = 8'h00;
    for (int i = 0; i < 30; i++) cyc(1, 0);
    chk("cool30_ready_lo", rd0, 0);
    cyc(0, 0);
    chk("cool30_ready_hi", rd0, 1);
    motion_x = 10'd0;
    motion_y = 10'd0;
    fire();
    chk("refire_shots", sf0, 2);
    chk("refire_x", bx0, 100);
    chk("refire_active", ba0, 1);

    // Off-screen exit at the right edge, cooldown of 2
    do_reset();
    motion_x = 10'd1;
    motion_y = 10'd0;
    fire();
    chk("exit_start_x", bx1, 637);
    cyc(1, 0);
    chk("exit_x1", bx1, 638);
    cyc(1, 0);
    chk("exit_x2", bx1, 639);
    cyc(1, 0);
    chk("exit_active", ba1, 0);
    chk("exit_hold_x", bx1, 639);
    cyc(1, 0);
    chk("exit_cool1", rd1, 0);
    cyc(1, 0);
    chk("exit_cool2", rd1, 0);
    cyc(0, 0);
    chk("exit_ready", rd1, 1);

    // Hit without a tick
    do_reset();
    fire();
    cyc(0, 1);
    chk("hit_notick_active", ba0, 0);
    chk("hit_notick_x", bx0, 100);

    // Reset mid-flight
    do_reset();
    motion_x = 10'd3;
    fire();
    cyc(1, 0);
    chk("mid_x", bx0, 103);
    Reset = 1'b1;
    cyc(0, 0);
    Reset = 1'b0;
    chk("mid_rst_ready", rd0, 1);
    chk("mid_rst_shots", sf0, 0);
    chk("mid_rst_x", bx0, 100);
    chk("mid_rst_y", by0, 400);
    chk("mid_rst_active", ba0, 0);

    // Key held for 100 frames: exactly one launch
    do_reset();
    motion_x = 10'd0;
    motion_y = 10'd0;
    keycode  = 8'h2C;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    chk("hold_shots", sf0, 1);
    chk("hold_ready", rd0, 1);
    keycode = 8'h00;

    // Gravity saturation with GRAV_DIV=1
    do_reset();
    motion_x = 10'd1;
    motion_y = 10'd5;
    fire();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      chk($sformatf("grav_y%0d", i), by2, gy[i]);
    end
    chk("grav_x", bx2, 110);
    cyc(1, 0);
    chk("grav_end_active", ba2, 0);
    chk("grav_end_y", by2, 474);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
